// File: rtl/serv_csr_irq.sv
// Bit-serial machine-mode CSR and interrupt unit for SERV: mstatus/mie/mip/mcause fields,
// NUM_IRQ external lines (edge or level per line) plus the machine timer, fixed-priority cause.
module serv_csr_irq #(
    parameter int                 NUM_IRQ  = 4,
    parameter logic [NUM_IRQ-1:0] IRQ_EDGE = '0
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_en,
    input  logic [4:0]         i_cnt,
    input  logic               i_mstatus_en,
    input  logic               i_mie_en,
    input  logic               i_mip_en,
    input  logic               i_mcause_en,
    input  logic [1:0]         i_csr_source,
    input  logic               i_d,
    input  logic               i_rf_csr_out,
    output logic               o_csr_in,
    output logic               o_q,
    input  logic               i_mtip,
    input  logic [NUM_IRQ-1:0] i_irq,
    output logic               o_new_irq,
    output logic               o_irq_active,
    input  logic               i_trap_taken,
    input  logic               i_mret,
    input  logic               i_e_op,
    input  logic               i_ebreak,
    input  logic               i_mem_misalign,
    input  logic               i_mem_cmd
);
    localparam logic [1:0] SRC_CSR = 2'b00;
    localparam logic [1:0] SRC_EXT = 2'b01;
    localparam logic [1:0] SRC_SET = 2'b10;
    localparam logic [1:0] SRC_CLR = 2'b11;

    logic               mie_q, mie_d, mpie_q, mpie_d, mtie_q, mtie_d;
    logic [NUM_IRQ-1:0] meie_q, meie_d, epend_q, epend_d, irq_q;
    logic [NUM_IRQ-1:0] pend, ext_hit, epend_set, epend_clr;
    logic [4:0]         code_q, code_d, irq_code, exc_code;
    logic               intr_q, intr_d, active_q, active;
    logic               rd_bit, csr_in;

    always_comb begin
        for (int k = 0; k < NUM_IRQ; k++) begin
            pend[k] = IRQ_EDGE[k] ? epend_q[k] : i_irq[k];
        end
    end

    assign ext_hit      = meie_q & pend;
    assign active       = mie_q & ((mtie_q & i_mtip) | (|ext_hit));
    assign o_irq_active = active;
    assign o_new_irq    = active & ~active_q;

    // Walk downwards so the lowest-numbered pending line wins; timer is the fallback.
    always_comb begin
        irq_code = 5'd7;
        for (int k = NUM_IRQ - 1; k >= 0; k--) begin
            if (ext_hit[k]) irq_code = 5'(16 + k);
        end
    end

    always_comb begin
        exc_code = 5'd0;
        if (i_e_op)              exc_code = i_ebreak ? 5'd3 : 5'd11;
        else if (i_mem_misalign) exc_code = i_mem_cmd ? 5'd6 : 5'd4;
    end

    always_comb begin
        rd_bit = 1'b0;
        if (i_mstatus_en) rd_bit = rd_bit | ((i_cnt == 5'd3) & mie_q) | ((i_cnt == 5'd7) & mpie_q);
        if (i_mie_en)     rd_bit = rd_bit | ((i_cnt == 5'd7) & mtie_q);
        if (i_mip_en)     rd_bit = rd_bit | ((i_cnt == 5'd7) & i_mtip);
        if (i_mcause_en)  rd_bit = rd_bit | ((i_cnt < 5'd5) & code_q[0]) | ((i_cnt == 5'd31) & intr_q);
        for (int k = 0; k < NUM_IRQ; k++) begin
            if (i_cnt == 5'(16 + k)) rd_bit = rd_bit | (i_mie_en & meie_q[k]) | (i_mip_en & pend[k]);
        end
    end

    assign o_q = (rd_bit & i_en) | i_rf_csr_out;

    always_comb begin
        case (i_csr_source)
            SRC_EXT: csr_in = i_d;
            SRC_SET: csr_in = o_q | i_d;
            SRC_CLR: csr_in = o_q & ~i_d;
            default: csr_in = o_q;
        endcase
    end
    assign o_csr_in = csr_in;

    // Later assignments win: serial write < mret < trap entry.
    always_comb begin
        mie_d  = mie_q;
        mpie_d = mpie_q;
        mtie_d = mtie_q;
        meie_d = meie_q;
        code_d = code_q;
        intr_d = intr_q;
        if (i_en && i_mstatus_en && i_cnt == 5'd3) mie_d  = csr_in;
        if (i_en && i_mstatus_en && i_cnt == 5'd7) mpie_d = csr_in;
        if (i_en && i_mie_en && i_cnt == 5'd7)     mtie_d = csr_in;
        for (int k = 0; k < NUM_IRQ; k++) begin
            if (i_en && i_mie_en && i_cnt == 5'(16 + k)) meie_d[k] = csr_in;
        end
        if (i_en && i_mcause_en && i_cnt < 5'd5)    code_d = {csr_in, code_q[4:1]};
        if (i_en && i_mcause_en && i_cnt == 5'd31)  intr_d = csr_in;
        if (i_mret) begin
            mie_d  = mpie_q;
            mpie_d = 1'b1;
        end
        if (i_trap_taken) begin
            mie_d  = 1'b0;
            mpie_d = mie_q;
            intr_d = active;
            code_d = active ? irq_code : exc_code;
        end
    end

    // Edge latches: a new rising edge overrides a same-cycle software clear.
    always_comb begin
        for (int k = 0; k < NUM_IRQ; k++) begin
            epend_clr[k] = i_en & i_mip_en & (i_cnt == 5'(16 + k)) & ~csr_in;
        end
        epend_set = IRQ_EDGE & i_irq & ~irq_q;
        epend_d   = IRQ_EDGE & (epend_set | (epend_q & ~epend_clr));
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mie_q    <= 1'b0;
            mpie_q   <= 1'b0;
            mtie_q   <= 1'b0;
            meie_q   <= '0;
            epend_q  <= '0;
            irq_q    <= '0;
            code_q   <= 5'd0;
            intr_q   <= 1'b0;
            active_q <= 1'b0;
        end else begin
            mie_q    <= mie_d;
            mpie_q   <= mpie_d;
            mtie_q   <= mtie_d;
            meie_q   <= meie_d;
            epend_q  <= epend_d;
            irq_q    <= i_irq;
            code_q   <= code_d;
            intr_q   <= intr_d;
            active_q <= active;
        end
    end
endmodule

// File: tb/tb_serv_csr_irq.sv
// Scoreboard bench for serv_csr_irq: stimulus queues expected CSR words and pin snapshots,
// a negedge monitor assembles serial reads and compares against the queue.
module tb_serv_csr_irq;
    localparam int NIRQ = 4;
    localparam logic [3:0] SEL_MSTATUS = 4'b0001;
    localparam logic [3:0] SEL_MIE     = 4'b0010;
    localparam logic [3:0] SEL_MIP     = 4'b0100;
    localparam logic [3:0] SEL_MCAUSE  = 4'b1000;

    logic            clk = 1'b0;
    logic            i_rst_n, i_en, i_mstatus_en, i_mie_en, i_mip_en, i_mcause_en;
    logic [4:0]      i_cnt;
    logic [1:0]      i_csr_source;
    logic            i_d, i_rf_csr_out, o_csr_in, o_q, i_mtip;
    logic [NIRQ-1:0] i_irq;
    logic            o_new_irq, o_irq_active, i_trap_taken, i_mret;
    logic            i_e_op, i_ebreak, i_mem_misalign, i_mem_cmd;

    serv_csr_irq #(.NUM_IRQ(NIRQ), .IRQ_EDGE(4'b0010)) dut (
        .i_clk(clk), .i_rst_n(i_rst_n), .i_en(i_en), .i_cnt(i_cnt),
        .i_mstatus_en(i_mstatus_en), .i_mie_en(i_mie_en), .i_mip_en(i_mip_en),
        .i_mcause_en(i_mcause_en), .i_csr_source(i_csr_source), .i_d(i_d),
        .i_rf_csr_out(i_rf_csr_out), .o_csr_in(o_csr_in), .o_q(o_q), .i_mtip(i_mtip),
        .i_irq(i_irq), .o_new_irq(o_new_irq), .o_irq_active(o_irq_active),
        .i_trap_taken(i_trap_taken), .i_mret(i_mret), .i_e_op(i_e_op), .i_ebreak(i_ebreak),
        .i_mem_misalign(i_mem_misalign), .i_mem_cmd(i_mem_cmd)
    );

    always #5 clk = ~clk;

    bit          exp_word_q[$];
    logic [31:0] exp_val_q[$];
    string       exp_name_q[$];
    logic        capture = 1'b0, probe = 1'b0, done = 1'b0;
    logic [31:0] word;
    int          checks = 0, errors = 0;

    task automatic compare_next(input bit is_word, input logic [31:0] act);
        bit          k;
        logic [31:0] e;
        string       n;
        checks++;
        if (exp_val_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: actual %h with nothing expected", act);
        end else begin
            k = exp_word_q.pop_front();
            e = exp_val_q.pop_front();
            n = exp_name_q.pop_front();
            if (k != is_word || act !== e) begin
                errors++;
                $display("FAIL %s: actual %h required %h", n, act, e);
            end
        end
    endtask

    // Monitor: pin snapshots are {new_irq, irq_active, q, csr_in}.
    always @(negedge clk) begin
        if (capture && i_en) begin
            word[i_cnt] = o_q;
            if (i_cnt == 5'd31) compare_next(1'b1, word);
        end
        if (probe) compare_next(1'b0, {28'd0, o_new_irq, o_irq_active, o_q, o_csr_in});
        if (done) begin
            if (exp_val_q.size() != 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_leftover: actual %0d pending required 0", exp_val_q.size());
            end
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_pins(input string n, input logic [3:0] v);
        exp_word_q.push_back(1'b0);
        exp_val_q.push_back({28'd0, v});
        exp_name_q.push_back(n);
        probe = 1'b1;
        @(negedge clk);
        #1;
        probe = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic xfer(input logic [3:0] sel, input logic [1:0] src, input logic [31:0] data,
                        input bit cap, input int pulse_at);
        capture = cap;
        {i_mcause_en, i_mip_en, i_mie_en, i_mstatus_en} = sel;
        i_csr_source = src;
        for (int c = 0; c < 32; c++) begin
            i_en  = 1'b1;
            i_cnt = c[4:0];
            i_d   = data[c];
            if (c == pulse_at) i_irq[1] = 1'b1;
            else if (c == pulse_at + 1) i_irq[1] = 1'b0;
            step();
        end
        i_en = 1'b0;
        {i_mcause_en, i_mip_en, i_mie_en, i_mstatus_en} = 4'b0000;
        i_csr_source = 2'b00;
        i_d = 1'b0;
        capture = 1'b0;
    endtask

    task automatic read_csr(input logic [3:0] sel, input string n, input logic [31:0] exp);
        exp_word_q.push_back(1'b1);
        exp_val_q.push_back(exp);
        exp_name_q.push_back(n);
        xfer(sel, 2'b00, 32'd0, 1'b1, -1);
    endtask

    task automatic trap(input logic eop, input logic ebrk, input logic mis, input logic cmd);
        i_e_op = eop; i_ebreak = ebrk; i_mem_misalign = mis; i_mem_cmd = cmd;
        i_trap_taken = 1'b1;
        step();
        i_trap_taken = 1'b0;
        i_e_op = 1'b0; i_ebreak = 1'b0; i_mem_misalign = 1'b0; i_mem_cmd = 1'b0;
    endtask

    task automatic mret();
        i_mret = 1'b1;
        step();
        i_mret = 1'b0;
    endtask

    logic [31:0] d88;

    initial begin
        i_rst_n = 1'b0; i_en = 1'b0; i_cnt = 5'd0; i_d = 1'b0;
        {i_mcause_en, i_mip_en, i_mie_en, i_mstatus_en} = 4'b0000;
        i_csr_source = 2'b00; i_rf_csr_out = 1'b0; i_mtip = 1'b0; i_irq = '0;
        i_trap_taken = 1'b0; i_mret = 1'b0;
        i_e_op = 1'b0; i_ebreak = 1'b0; i_mem_misalign = 1'b0; i_mem_cmd = 1'b0;
        d88 = 32'h88;
        step(); step();

        // T1: reset state, then reset in the middle of an mstatus write.
        expect_pins("reset_pins", 4'b0000);
        i_rst_n = 1'b1;
        step();
        i_mstatus_en = 1'b1;
        i_csr_source = 2'b01;
        for (int c = 0; c < 10; c++) begin
            i_en = 1'b1; i_cnt = c[4:0]; i_d = d88[c];
            step();
        end
        i_rst_n = 1'b0; i_en = 1'b0; i_mstatus_en = 1'b0; i_csr_source = 2'b00; i_d = 1'b0;
        expect_pins("midxfer_reset_pins", 4'b0000);
        i_rf_csr_out = 1'b1;
        expect_pins("reset_rf_passthru", 4'b0011);
        i_rf_csr_out = 1'b0;
        i_rst_n = 1'b1;
        step();
        read_csr(SEL_MSTATUS, "reset_mstatus", 32'h0);
        read_csr(SEL_MIE, "reset_mie", 32'h0);
        read_csr(SEL_MCAUSE, "reset_mcause", 32'h0);

        // T2: mstatus write, trap entry, mret.
        xfer(SEL_MSTATUS, 2'b01, 32'h88, 1'b0, -1);
        read_csr(SEL_MSTATUS, "mstatus_write", 32'h88);
        trap(1'b0, 1'b0, 1'b0, 1'b0);
        read_csr(SEL_MSTATUS, "mstatus_after_trap", 32'h80);
        mret();
        read_csr(SEL_MSTATUS, "mstatus_after_mret", 32'h88);

        // T3: edge line 1 single-cycle pulse.
        xfer(SEL_MIE, 2'b01, 32'h0002_0000, 1'b0, -1);
        expect_pins("t3_idle_pins", 4'b0000);
        i_irq = 4'b0010;
        step();
        i_irq = 4'b0000;
        expect_pins("t3_new_irq_rise", 4'b1100);
        expect_pins("t3_new_irq_oneshot", 4'b0100);
        read_csr(SEL_MIP, "t3_mip_pending", 32'h0002_0000);
        trap(1'b0, 1'b0, 1'b0, 1'b0);
        expect_pins("t3_inactive_after_trap", 4'b0000);
        read_csr(SEL_MCAUSE, "t3_mcause_irq1", 32'h8000_0011);
        xfer(SEL_MIP, 2'b11, 32'h0002_0000, 1'b0, -1);
        read_csr(SEL_MIP, "t3_mip_cleared", 32'h0);

        // T4: priority among level line 0, edge line 1 and timer.
        xfer(SEL_MIE, 2'b01, 32'h000F_0080, 1'b0, -1);
        i_mtip = 1'b1;
        i_irq  = 4'b0011;
        step();
        i_irq  = 4'b0001;
        step();
        mret();
        expect_pins("t4_active_rise", 4'b1100);
        trap(1'b0, 1'b0, 1'b0, 1'b0);
        read_csr(SEL_MCAUSE, "t4_mcause_line0", 32'h8000_0010);
        i_irq = 4'b0000;
        mret();
        trap(1'b0, 1'b0, 1'b0, 1'b0);
        read_csr(SEL_MCAUSE, "t4_mcause_line1", 32'h8000_0011);
        xfer(SEL_MIP, 2'b11, 32'h0002_0000, 1'b0, -1);
        mret();
        trap(1'b0, 1'b0, 1'b0, 1'b0);
        read_csr(SEL_MCAUSE, "t4_mcause_timer", 32'h8000_0007);
        i_mtip = 1'b0;

        // T5: new edge coincides with a software clear of the same bit.
        i_irq = 4'b0010;
        step();
        i_irq = 4'b0000;
        step();
        xfer(SEL_MIP, 2'b11, 32'h0002_0000, 1'b0, 17);
        read_csr(SEL_MIP, "t5_set_beats_clear", 32'h0002_0000);

        // T6: exception causes and direct mcause write.
        trap(1'b1, 1'b1, 1'b0, 1'b0);
        read_csr(SEL_MCAUSE, "t6_ebreak", 32'h3);
        trap(1'b1, 1'b0, 1'b0, 1'b0);
        read_csr(SEL_MCAUSE, "t6_ecall", 32'hB);
        trap(1'b0, 1'b0, 1'b1, 1'b1);
        read_csr(SEL_MCAUSE, "t6_misalign_store", 32'h6);
        trap(1'b0, 1'b0, 1'b1, 1'b0);
        read_csr(SEL_MCAUSE, "t6_misalign_load", 32'h4);
        xfer(SEL_MCAUSE, 2'b01, 32'h8000_001F, 1'b0, -1);
        read_csr(SEL_MCAUSE, "t6_mcause_ext", 32'h8000_001F);
        read_csr(SEL_MCAUSE, "t6_mcause_reread", 32'h8000_001F);

        done = 1'b1;
        step();
        step();
    end
endmodule
